// File: rtl/real_integ_dump_pkg.sv
// Shared types and elaboration-time sizing helpers for the real_integ_dump block.
package real_integ_dump_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } integ_state_t;

    // Signed shift that moves an input mantissa onto the output exponent; positive = left.
    function automatic int align_shift(input int in_exp, input int out_exp);
        return in_exp - out_exp;
    endfunction

    function automatic int unsigned acc_width(input int in_w, input int in_exp,
                                              input int out_w, input int out_exp,
                                              input int dump_len);
        int shift;
        int aligned_w;
        int base_w;
        shift     = align_shift(in_exp, out_exp);
        aligned_w = in_w + shift;
        if (aligned_w < 1) aligned_w = 1;
        base_w    = (aligned_w > out_w) ? aligned_w : out_w;
        return base_w + $clog2(dump_len) + 1;
    endfunction

    function automatic int unsigned cnt_width(input int dump_len);
        return $clog2(dump_len + 1);
    endfunction

endpackage

// File: rtl/real_integ_dump_sat_trunc.sv
// Reduces the wide accumulator to the output width: clamp when SVREAL_INTEG_DUMP_SAT_EN
// is defined, two's-complement wrap otherwise.
module real_sat_trunc #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 24
) (
    input  logic signed [IN_W-1:0]  acc,
    output logic        [OUT_W-1:0] q,
    output logic                    sat
);

`ifdef SVREAL_INTEG_DUMP_SAT_EN
    logic fits_c;

    // The value fits when every bit above the output sign bit equals the sign.
    always_comb begin
        fits_c = (acc[IN_W-1:OUT_W-1] == '0) || (acc[IN_W-1:OUT_W-1] == '1);
        sat    = ~fits_c;
        if (fits_c) begin
            q = acc[OUT_W-1:0];
        end else if (acc[IN_W-1]) begin
            q = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            q = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    logic unused_hi;

    assign q         = acc[OUT_W-1:0];
    assign sat       = 1'b0;
    assign unused_hi = ^acc[IN_W-1:OUT_W];
`endif

endmodule

// File: rtl/real_integ_dump.sv
// Fixed-point integrate-and-dump: sums DUMP_LEN accepted samples (or up to a flush) and
// emits the registered sum with a one-cycle valid pulse. Option: SVREAL_INTEG_DUMP_SAT_EN.
module real_integ_dump
    import real_integ_dump_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int          IN_EXP    = -8,
    parameter int unsigned OUT_WIDTH = 24,
    parameter int          OUT_EXP   = -8,
    parameter int unsigned DUMP_LEN  = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 cke_i,
    input  logic                                 in_valid_i,
    input  logic [IN_WIDTH-1:0]                  d_i,
    input  logic                                 flush_i,
    output logic [OUT_WIDTH-1:0]                 q_o,
    output logic [cnt_width(DUMP_LEN)-1:0]       cnt_o,
    output logic                                 out_valid_o,
    output logic                                 sat_o
);

    localparam int          SHIFT = align_shift(IN_EXP, OUT_EXP);
    localparam int unsigned SHL   = (SHIFT >= 0) ? SHIFT : 0;
    localparam int unsigned SHR   = (SHIFT < 0) ? -SHIFT : 0;
    localparam int unsigned ACC_W = acc_width(IN_WIDTH, IN_EXP, OUT_WIDTH, OUT_EXP, DUMP_LEN);
    localparam int unsigned CNT_W = cnt_width(DUMP_LEN);

    integ_state_t             state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [CNT_W-1:0]  cnt_q, cnt_d;

    logic                     accept_c;
    logic                     dump_c;
    logic signed [ACC_W-1:0]  d_ext_c;
    logic signed [ACC_W-1:0]  samp_c;
    logic signed [ACC_W-1:0]  sum_c;
    logic        [CNT_W-1:0]  cnt_sum_c;
    logic        [OUT_WIDTH-1:0] q_c;
    logic                     sat_c;

    // Right shift is arithmetic, so truncation goes toward minus infinity.
    always_comb begin
        accept_c  = cke_i & in_valid_i;
        d_ext_c   = ACC_W'($signed(d_i));
        samp_c    = (d_ext_c <<< SHL) >>> SHR;
        sum_c     = accept_c ? (acc_q + samp_c) : acc_q;
        cnt_sum_c = cnt_q + CNT_W'(accept_c);
    end

    real_sat_trunc #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_WIDTH)
    ) u_sat_trunc (
        .acc (sum_c),
        .q   (q_c),
        .sat (sat_c)
    );

    // Next-state: a dump clears the partial sum on the same edge, so no bubble follows.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dump_c  = 1'b0;
        if (cke_i) begin
            dump_c = flush_i || (accept_c && (cnt_sum_c == CNT_W'(DUMP_LEN)));
            case (state_q)
                ST_IDLE: begin
                    if (dump_c) begin
                        acc_d = '0;
                        cnt_d = '0;
                    end else if (accept_c) begin
                        acc_d   = sum_c;
                        cnt_d   = cnt_sum_c;
                        state_d = ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (dump_c) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else if (accept_c) begin
                        acc_d = sum_c;
                        cnt_d = cnt_sum_c;
                    end
                end
                default: begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            q_o         <= '0;
            cnt_o       <= '0;
            out_valid_o <= 1'b0;
            sat_o       <= 1'b0;
        end else if (cke_i) begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_o <= dump_c;
            if (dump_c) begin
                q_o   <= q_c;
                cnt_o <= cnt_sum_c;
                sat_o <= sat_c;
            end
        end
    end

endmodule

// File: doc/real_integ_dump.md
# real_integ_dump

Fixed-point integrate-and-dump stage for svreal datapaths. It accumulates a stream of fixed-point samples over a programmable number of accepted samples. It then emits the sum as a single registered fixed-point word with a one-cycle valid pulse. The block sits directly upstream of the fixed-point DFF/register stages and shares their clock, reset and clock-enable so the consumer can capture `q_o` on `out_valid_o`.

## Interface
- `IN_WIDTH`, 16: input mantissa width; input value = `d_i`·2^`IN_EXP`.
- `IN_EXP`, -8: input exponent.
- `OUT_WIDTH`, 24: output mantissa width.
- `OUT_EXP`, -8: output exponent.
- `DUMP_LEN`, 8: number of accepted samples per dump; must be ≥1.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `cke_i`  in  1  clock enable; when low, all state holds.
- `in_valid_i`  in  1  `d_i` is a sample this cycle.
- `d_i`  in  `IN_WIDTH`  signed two's-complement input mantissa.
- `flush_i`  in  1  forces an early dump of the partial sum.
- `q_o`  out  `OUT_WIDTH`  signed dumped sum, value = `q_o`·2^`OUT_EXP`.
- `cnt_o`  out  $clog2(`DUMP_LEN`+1)  number of samples contained in `q_o`.
- `out_valid_o`  out  1  one-cycle pulse: `q_o`/`cnt_o` are new.
- `sat_o`  out  1  the dumped sum was clipped.

## Operation
- Sample accepted on an edge with `cke_i & in_valid_i & ~rst_i`.
- Alignment to `OUT_EXP`:
  - If `IN_EXP` ≥ `OUT_EXP`, sign-extend and shift left by `IN_EXP`−`OUT_EXP`.
  - Otherwise, arithmetic right shift by `OUT_EXP`−`IN_EXP`, truncating toward −∞.
- Accumulator width is `ACC_WIDTH` = max(aligned input width, `OUT_WIDTH`) + $clog2(`DUMP_LEN`) + 1. The accumulator never overflows internally.
- Counter `cnt` counts accepted samples, from 0 up to `DUMP_LEN`.
- FSM states:
  - `ST_IDLE`: after reset, `acc`=0, `cnt`=0. Moves to `ST_ACC` on the first accepted sample, or dumps on `flush_i`.
  - `ST_ACC`: accumulates. Dumps when an accepted sample makes `cnt` reach `DUMP_LEN`, or when `flush_i`=1.
- Dump edge:
  - `q_o` ← `acc` + current sample (if accepted), reduced to `OUT_WIDTH`.
  - `cnt_o` ← sample count including the current sample.
  - `out_valid_o` ← 1.
  - `acc` and `cnt` cleared; FSM → `ST_IDLE`.
  - A dump edge carries no bubble: the next sample is accepted on the following edge.
- Non-dump enabled edge: `out_valid_o` ← 0.
- Flush with `cnt`=0 and no sample: dump `q_o`=0, `cnt_o`=0, `out_valid_o`=1.
- `flush_i` together with the `DUMP_LEN`-th sample produces a single dump, not two.
- `flush_i` with `cke_i`=0 is ignored.

## Timing
- Reset values: `q_o`=0, `cnt_o`=0, `out_valid_o`=0, `sat_o`=0, `acc`=0, `cnt`=0, FSM=`ST_IDLE`.
- Reset has priority over `cke_i`, `in_valid_i` and `flush_i`.
- Reset mid-accumulation discards the partial sum; no dump occurs.
- Latency: `q_o` and `out_valid_o` are visible after the edge that accepts the `DUMP_LEN`-th sample (registered, 1 edge).
- Every output is registered; none is combinational from inputs.
- `cke_i`=0 holds all registers, including a high `out_valid_o`. The consumer is gated by the same `cke_i`, so each pulse is seen exactly once.

## Configuration
- Macro: `SVREAL_INTEG_DUMP_SAT_EN`.
- Defined: the dump result clamps to [−2^(`OUT_WIDTH`−1), 2^(`OUT_WIDTH`−1)−1]. `sat_o` is registered with `q_o` and is 1 when a clamp occurred.
- Undefined: `q_o` takes the low `OUT_WIDTH` bits (two's-complement wrap), and `sat_o` is tied to 0.

## Structure
- Package `real_integ_dump_pkg` holds:
  - state enum `integ_state_t` (`ST_IDLE`, `ST_ACC`);
  - functions `acc_width()` and `cnt_width()`;
  - function `align_shift()` returning the signed shift amount.
- One combinational sub-module, `real_sat_trunc`: parameters `IN_W` and `OUT_W`; input `acc`; outputs `q` and `sat`. It implements both the clamp and the wrap behaviour under the macro.

## Test plan
- Default parameters, `DUMP_LEN`=4, four samples of 0x0180 (1.5) → one pulse, `q_o`=0x000600 (6.0), `cnt_o`=4, `sat_o`=0.
- Samples on consecutive cycles across two dumps (0x0100 ×4, then 0xFF00 ×4) → pulses 4 edges apart, `q_o`=0x000400 then 0xFFFC00, no dropped sample.
- `flush_i` after 2 samples of 0x0040, then `flush_i` alone with `cnt`=0:
  - first → `q_o`=0x000080, `cnt_o`=2;
  - second → `q_o`=0, `cnt_o`=0, `out_valid_o`=1.
- `OUT_EXP`=-10, sample 0x0100 (1.0) ×4 → `q_o`=0x001000. With `OUT_EXP`=-6, sample 0x0001 → contributes 0; sample 0xFFFF → contributes −1 LSB.
- `OUT_WIDTH`=16, `DUMP_LEN`=4, samples 0x7FFF ×4:
  - with the macro → `q_o`=0x7FFF, `sat_o`=1;
  - without it → `q_o`=0xFFFC, `sat_o`=0.
- `cke_i` low for 3 cycles mid-accumulation and during a high `out_valid_o` → state frozen, pulse held. `rst_i` after 2 samples → no pulse; the next 4 samples dump only their own sum.
